multicycle_ctrl: RTL and testbench

Multicycle sequencer for the LEGv8-subset datapath: the existing register file, ALU, flag registers, sign extenders, PC adders and data memory, with control no longer decoded combinationally in a single cycle. It latches the fetched instruction, then steps FETCH/DECODE/EXEC/MEM/WB. It drives every datapath control strobe per state, stalls on data-memory handshakes and resolves branches from the flag and ALU-zero inputs. It sits between instruction memory and the existing datapath, replacing the per-instruction combinational control decoder.

---
 rtl/multicycle_ctrl_if.sv | 38 +++
 rtl/multicycle_ctrl.sv | 167 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Signal bundle between the multicycle sequencer and the instruction memory, data memory and LEGv8 datapath.
// The master modport is the sequencer; the slave modport is the datapath/memory side.
interface multicycle_ctrl_if;
    logic [31:0] instr;
    logic        alu_zero;
    logic        flag_n;
    logic        flag_z;
    logic        flag_v;
    logic        flag_c;
    logic        dmem_ready;

    logic [31:0] ir;
    logic        ir_load;
    logic        pc_write;
    logic        BrTaken;
    logic        UncondBr;
    logic        Reg2Loc;
    logic        ALUSrc;
    logic        MemToReg;
    logic        RegWrite;
    logic [2:0]  ALUOp;
    logic        flag_write;
    logic        dmem_req;
    logic        MemWrite;
    logic        halted;

    modport master (
        input  instr, alu_zero, flag_n, flag_z, flag_v, flag_c, dmem_ready,
        output ir, ir_load, pc_write, BrTaken, UncondBr, Reg2Loc, ALUSrc,
               MemToReg, RegWrite, ALUOp, flag_write, dmem_req, MemWrite, halted
    );

    modport slave (
        output instr, alu_zero, flag_n, flag_z, flag_v, flag_c, dmem_ready,
        input  ir, ir_load, pc_write, BrTaken, UncondBr, Reg2Loc, ALUSrc,
               MemToReg, RegWrite, ALUOp, flag_write, dmem_req, MemWrite, halted
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the LEGv8-subset datapath.
// Strobes decode from the registered state and ir; only BrTaken (EXEC) and the STUR completion follow inputs.
module multicycle_ctrl (
    input  logic              clk,
    input  logic              reset,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
    typedef enum logic [3:0] {
        OP_ILLEGAL, OP_ADDI, OP_ADDS, OP_SUBS, OP_AND, OP_EOR,
        OP_LDUR, OP_STUR, OP_B, OP_BCOND, OP_CBZ
    } op_t;

    localparam logic [2:0] ALU_PASS_B = 3'b000;
    localparam logic [2:0] ALU_ADD    = 3'b010;
    localparam logic [2:0] ALU_SUB    = 3'b011;
    localparam logic [2:0] ALU_AND    = 3'b100;
    localparam logic [2:0] ALU_XOR    = 3'b110;

    state_t      state;
    logic [31:0] ir;
    logic        reset_q;
    logic        active;
    op_t         op;
    logic        is_rtype;
    logic        is_mem;
    logic        is_branch;
    logic        uses_imm;
    logic        cond_taken;
    logic [2:0]  alu_op;
    logic        unused;

    // The carry flag feeds none of the supported branch conditions.
    assign unused = bus.flag_c;

    // Strobes stay quiet while reset is high and for one cycle after it drops.
    assign active = !reset && !reset_q;
    assign bus.ir = ir;

    // NOTE: every combinational output gets a default before the case so no latch is inferred.
    always_comb begin
        op = OP_ILLEGAL;
        casez (ir[31:21])
            11'b1001000100?: op = OP_ADDI;
            11'b10101011000: op = OP_ADDS;
            11'b11101011000: op = OP_SUBS;
            11'b10001010000: op = OP_AND;
            11'b11001010000: op = OP_EOR;
            11'b11111000010: op = OP_LDUR;
            11'b11111000000: op = OP_STUR;
            11'b000101?????: op = OP_B;
            11'b01010100???: op = OP_BCOND;
            11'b10110100???: op = OP_CBZ;
            default:         op = OP_ILLEGAL;
        endcase
    end

    assign is_rtype  = op inside {OP_ADDS, OP_SUBS, OP_AND, OP_EOR};
    assign is_mem    = op inside {OP_LDUR, OP_STUR};
    assign is_branch = op inside {OP_B, OP_BCOND, OP_CBZ};
    assign uses_imm  = op inside {OP_ADDI, OP_LDUR, OP_STUR};

    always_comb begin
        alu_op = ALU_PASS_B;
        case (op)
            OP_ADDI, OP_ADDS, OP_LDUR, OP_STUR: alu_op = ALU_ADD;
            OP_SUBS:                            alu_op = ALU_SUB;
            OP_AND:                             alu_op = ALU_AND;
            OP_EOR:                             alu_op = ALU_XOR;
            default:                            alu_op = ALU_PASS_B;
        endcase
    end

    always_comb begin
        cond_taken = 1'b0;
        case (ir[4:0])
            5'h00:   cond_taken = bus.flag_z;
            5'h01:   cond_taken = !bus.flag_z;
            5'h0A:   cond_taken = (bus.flag_n == bus.flag_v);
            5'h0B:   cond_taken = (bus.flag_n != bus.flag_v);
            5'h0C:   cond_taken = !bus.flag_z && (bus.flag_n == bus.flag_v);
            5'h0D:   cond_taken = bus.flag_z || (bus.flag_n != bus.flag_v);
            default: cond_taken = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            ir      <= '0;
            reset_q <= 1'b1;
        end else begin
            reset_q <= 1'b0;
            case (state)
                FETCH: begin
                    if (!reset_q) begin
                        ir    <= bus.instr;
                        state <= DECODE;
                    end
                end
                DECODE:  state <= (op == OP_ILLEGAL) ? HALT : EXEC;
                EXEC: begin
                    if (is_branch)   state <= FETCH;
                    else if (is_mem) state <= MEM;
                    else             state <= WB;
                end
                MEM: begin
                    if (bus.dmem_ready) state <= (op == OP_STUR) ? FETCH : WB;
                end
                WB:      state <= FETCH;
                HALT:    state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end

    always_comb begin
        bus.ir_load    = 1'b0;
        bus.pc_write   = 1'b0;
        bus.BrTaken    = 1'b0;
        bus.UncondBr   = 1'b0;
        bus.Reg2Loc    = 1'b0;
        bus.ALUSrc     = 1'b0;
        bus.MemToReg   = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.ALUOp      = ALU_PASS_B;
        bus.flag_write = 1'b0;
        bus.dmem_req   = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.halted     = 1'b0;
        if (active) begin
            case (state)
                FETCH:  bus.ir_load = 1'b1;
                DECODE: bus.Reg2Loc = is_rtype;
                EXEC: begin
                    bus.ALUSrc     = uses_imm;
                    bus.ALUOp      = alu_op;
                    bus.flag_write = op inside {OP_ADDS, OP_SUBS};
                    if (is_branch) begin
                        bus.pc_write = 1'b1;
                        bus.UncondBr = (op == OP_B);
                        bus.BrTaken  = (op == OP_B)
                                    || (op == OP_CBZ && bus.alu_zero)
                                    || (op == OP_BCOND && cond_taken);
                    end
                end
                MEM: begin
                    bus.ALUSrc   = uses_imm;
                    bus.ALUOp    = alu_op;
                    bus.dmem_req = 1'b1;
                    bus.MemWrite = (op == OP_STUR);
                    bus.pc_write = (op == OP_STUR) && bus.dmem_ready;
                end
                WB: begin
                    bus.ALUSrc   = uses_imm;
                    bus.ALUOp    = alu_op;
                    bus.RegWrite = 1'b1;
                    bus.pc_write = 1'b1;
                    bus.MemToReg = (op == OP_LDUR);
                end
                HALT:    bus.halted = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus random instruction streams,
// each compared cycle by cycle against an expected strobe schedule built from the instruction's semantics.
module tb_multicycle_ctrl;
    typedef enum logic [3:0] {
        K_ADDI, K_ADDS, K_SUBS, K_AND, K_EOR, K_LDUR, K_STUR, K_B, K_BCOND, K_CBZ, K_ILL
    } kind_t;

    typedef struct packed {
        logic       ir_load;
        logic       pc_write;
        logic       BrTaken;
        logic       UncondBr;
        logic       Reg2Loc;
        logic       ALUSrc;
        logic       MemToReg;
        logic       RegWrite;
        logic [2:0] ALUOp;
        logic       flag_write;
        logic       dmem_req;
        logic       MemWrite;
        logic       halted;
    } ctl_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_assert = 0;
    int   n_fail = 0;
    ctl_t exp_q[$];
    logic [4:0] cond_pool [11] = '{5'h00, 5'h01, 5'h0A, 5'h0B, 5'h0C, 5'h0D,
                                   5'h02, 5'h0E, 5'h0F, 5'h10, 5'h1A};

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic ctl_t sample();
        ctl_t s;
        s = '{bus.ir_load, bus.pc_write, bus.BrTaken, bus.UncondBr, bus.Reg2Loc, bus.ALUSrc,
              bus.MemToReg, bus.RegWrite, bus.ALUOp, bus.flag_write, bus.dmem_req,
              bus.MemWrite, bus.halted};
        return s;
    endfunction

    function automatic logic [31:0] encode(input kind_t k, input logic [4:0] cond);
        logic [31:0] r;
        r = $urandom;
        case (k)
            K_ADDI:  return {10'b1001000100, r[21:0]};
            K_ADDS:  return {11'b10101011000, r[20:0]};
            K_SUBS:  return {11'b11101011000, r[20:0]};
            K_AND:   return {11'b10001010000, r[20:0]};
            K_EOR:   return {11'b11001010000, r[20:0]};
            K_LDUR:  return {11'b11111000010, r[20:0]};
            K_STUR:  return {11'b11111000000, r[20:0]};
            K_B:     return {6'b000101, r[25:0]};
            K_BCOND: return {8'b01010100, r[23:5], cond};
            K_CBZ:   return {8'b10110100, r[23:0]};
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Branch condition in terms of signed/equality comparison outcomes.
    function automatic logic cond_holds(input logic [4:0] c, input logic n, input logic z, input logic v);
        logic eq;
        logic lt;
        eq = z;
        lt = n ^ v;
        case (c)
            5'h00:   return eq;
            5'h01:   return !eq;
            5'h0A:   return !lt;
            5'h0B:   return lt;
            5'h0C:   return !eq && !lt;
            5'h0D:   return eq || lt;
            default: return 1'b0;
        endcase
    endfunction

    // Expected per-cycle strobes for one instruction; w is the MEM wait count (or HALT length).
    task automatic build_plan(input kind_t k, input logic [4:0] cond, input int w,
                              input logic [3:0] nzvc, input logic az);
        ctl_t c;
        logic [2:0] op;
        logic imm, alu_kind, mem_kind, br_kind;
        op = (k inside {K_ADDI, K_ADDS, K_LDUR, K_STUR}) ? 3'b010 :
             (k == K_SUBS) ? 3'b011 : (k == K_AND) ? 3'b100 : (k == K_EOR) ? 3'b110 : 3'b000;
        imm      = k inside {K_ADDI, K_LDUR, K_STUR};
        alu_kind = k inside {K_ADDI, K_ADDS, K_SUBS, K_AND, K_EOR};
        mem_kind = k inside {K_LDUR, K_STUR};
        br_kind  = k inside {K_B, K_BCOND, K_CBZ};
        exp_q.delete();
        c = '0; c.ir_load = 1'b1; exp_q.push_back(c);
        c = '0; c.Reg2Loc = k inside {K_ADDS, K_SUBS, K_AND, K_EOR}; exp_q.push_back(c);
        if (k == K_ILL) begin
            for (int i = 0; i < w; i++) begin
                c = '0; c.halted = 1'b1; exp_q.push_back(c);
            end
            return;
        end
        c = '0; c.ALUSrc = imm; c.ALUOp = op; c.flag_write = k inside {K_ADDS, K_SUBS};
        if (br_kind) begin
            c.pc_write = 1'b1;
            c.UncondBr = (k == K_B);
            c.BrTaken  = (k == K_B) ? 1'b1 : (k == K_CBZ) ? az : cond_holds(cond, nzvc[3], nzvc[2], nzvc[1]);
        end
        exp_q.push_back(c);
        if (mem_kind) begin
            for (int i = 0; i <= w; i++) begin
                c = '0; c.ALUSrc = 1'b1; c.ALUOp = op; c.dmem_req = 1'b1;
                c.MemWrite = (k == K_STUR);
                c.pc_write = (k == K_STUR) && (i == w);
                exp_q.push_back(c);
            end
        end
        if (alu_kind || k == K_LDUR) begin
            c = '0; c.ALUSrc = imm; c.ALUOp = op; c.RegWrite = 1'b1; c.pc_write = 1'b1;
            c.MemToReg = (k == K_LDUR);
            exp_q.push_back(c);
        end
    endtask

    task automatic run_instr(input kind_t k, input logic [31:0] insn, input int w,
                             input logic [3:0] nzvc, input logic az, input int max_cycles);
        ctl_t got;
        int   pcw;
        int   ncyc;
        logic mem_kind;
        pcw = 0;
        build_plan(k, insn[4:0], w, nzvc, az);
        mem_kind = k inside {K_LDUR, K_STUR};
        {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c} = nzvc;
        bus.alu_zero = az;
        ncyc = (exp_q.size() < max_cycles) ? exp_q.size() : max_cycles;
        for (int i = 0; i < ncyc; i++) begin
            bus.instr = (i == 0) ? insn : $urandom;
            if (mem_kind && i >= 3 && i <= 3 + w) bus.dmem_ready = (i == 3 + w);
            else bus.dmem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            got = sample();
            check($sformatf("%s c%0d ctl", k.name(), i), {17'b0, got}, {17'b0, exp_q[i]});
            if (i == 1) check($sformatf("%s ir", k.name()), bus.ir, insn);
            pcw += int'(got.pc_write);
            @(posedge clk);
            #1;
        end
        if (ncyc == exp_q.size() && k != K_ILL)
            check($sformatf("%s pc_write count", k.name()), pcw, 1);
    endtask

    task automatic do_reset(input int n);
        bus.dmem_ready = 1'b1;
        bus.alu_zero   = 1'b1;
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("reset c%0d ctl", i), {17'b0, sample()}, 32'h0);
            if (i > 0) check($sformatf("reset c%0d ir", i), bus.ir, 32'h0);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        @(negedge clk);
        check("post-release ctl", {17'b0, sample()}, 32'h0);
        check("post-release ir", bus.ir, 32'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        kind_t       k;
        logic [31:0] insn;
        bus.instr = 32'h0;
        {bus.flag_n, bus.flag_z, bus.flag_v, bus.flag_c} = 4'h0;

        do_reset(3);
        run_instr(K_ADDI, {10'b1001000100, 12'd5, 5'd31, 5'd1}, 0, 4'h0, 1'b0, 100);

        run_instr(K_SUBS, encode(K_SUBS, 5'h00), 0, 4'b0100, 1'b0, 100);
        run_instr(K_BCOND, encode(K_BCOND, 5'h00), 0, 4'b0100, 1'b0, 100);
        run_instr(K_SUBS, encode(K_SUBS, 5'h00), 0, 4'b0000, 1'b1, 100);
        run_instr(K_BCOND, encode(K_BCOND, 5'h00), 0, 4'b0000, 1'b1, 100);

        run_instr(K_LDUR, encode(K_LDUR, 5'h00), 3, 4'h0, 1'b0, 100);
        run_instr(K_STUR, encode(K_STUR, 5'h00), 0, 4'h0, 1'b0, 100);
        run_instr(K_CBZ, encode(K_CBZ, 5'h00), 0, 4'hF, 1'b0, 100);
        run_instr(K_CBZ, encode(K_CBZ, 5'h00), 0, 4'h0, 1'b1, 100);
        run_instr(K_B, encode(K_B, 5'h00), 0, 4'h0, 1'b0, 100);

        for (int i = 0; i < 11; i++) begin
            run_instr(K_BCOND, encode(K_BCOND, cond_pool[i]), 0, 4'($urandom), 1'($urandom), 100);
        end

        for (int i = 0; i < 80; i++) begin
            k = kind_t'($urandom_range(0, 9));
            insn = encode(k, cond_pool[$urandom_range(0, 10)]);
            run_instr(k, insn, $urandom_range(0, 4), 4'($urandom), 1'($urandom), 100);
        end

        // Reset during a STUR stall, with dmem_ready high in the reset cycle.
        run_instr(K_STUR, encode(K_STUR, 5'h00), 6, 4'h0, 1'b0, 5);
        do_reset(2);
        run_instr(K_ADDI, encode(K_ADDI, 5'h00), 0, 4'h0, 1'b0, 100);

        run_instr(K_ILL, 32'h0000_0000, 6, 4'h0, 1'b0, 100);
        do_reset(2);
        run_instr(K_EOR, encode(K_EOR, 5'h00), 0, 4'h0, 1'b0, 100);
        run_instr(K_LDUR, encode(K_LDUR, 5'h00), 0, 4'h0, 1'b0, 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
